// File: rtl/fifo_drain_ctrl_buf.sv
// Two-slot ring buffer that holds words captured from the FIFO.
// It presents the oldest word on head until that word is popped.
module drain_buf #(
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [data_width-1:0] wr_data,
    input  logic                  pop,
    output logic [data_width-1:0] head,
    output logic [1:0]            count
);
    localparam int BUF_DEPTH = 2;

    logic [data_width-1:0] slots [BUF_DEPTH];
    logic                  rd_ptr_reg;
    logic                  wr_ptr_reg;
    logic [1:0]            count_reg;
    logic [1:0]            count_next;

    genvar gi;
    generate
        for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slots[gi] <= '0;
                end else if (wr_en && (wr_ptr_reg == 1'(gi))) begin
                    slots[gi] <= wr_data;
                end
            end
        end
    endgenerate

    // A simultaneous write and pop leaves the occupancy unchanged.
    assign count_next = count_reg + {1'b0, wr_en} - {1'b0, pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            assert (!(count_reg == 2'd2 && wr_en && !pop));
            if (wr_en) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)   rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_next;
        end
    end

    assign head  = slots[rd_ptr_reg];
    assign count = count_reg;
endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side sequencer for a registered-output FIFO.
// It turns the FIFO's one-cycle read latency into a gap-free valid/ready stream.
module fifo_drain_ctrl #(
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [data_width-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic [data_width-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic                  busy
);
    logic       inflight_reg;
    logic       pop;
    logic [1:0] count;
    logic [2:0] committed;

    drain_buf #(.data_width(data_width)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight_reg),
        .wr_data (fifo_dout),
        .pop     (pop),
        .head    (data_out),
        .count   (count)
    );

    assign data_out_valid = (count != 2'd0);
    assign pop            = data_out_valid & data_out_ready;

    // Slots still claimed after this cycle. The same-cycle pop frees a slot
    // immediately, which keeps one word per cycle flowing under full readiness.
    assign committed  = {1'b0, count} + {2'b00, inflight_reg} - {2'b00, pop};
    assign fifo_rd_en = enable & ~fifo_empty & (committed < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= fifo_rd_en;
        end
    end

    assign busy = data_out_valid | inflight_reg;
endmodule
